// File: rtl/alu_pkg.sv
// alu_pkg: ALU opcode values, execute FSM states and opcode classification helpers
package alu_pkg;
  localparam logic [5:0] OP_ADD   = 6'd0;
  localparam logic [5:0] OP_SUB   = 6'd1;
  localparam logic [5:0] OP_AND   = 6'd2;
  localparam logic [5:0] OP_OR    = 6'd3;
  localparam logic [5:0] OP_SLT   = 6'd4;
  localparam logic [5:0] OP_MUL   = 6'd5;
  localparam logic [5:0] OP_LW    = 6'd8;
  localparam logic [5:0] OP_SW    = 6'd9;
  localparam logic [5:0] OP_ADDI  = 6'd10;
  localparam logic [5:0] OP_SUBI  = 6'd11;
  localparam logic [5:0] OP_SLTI  = 6'd12;
  localparam logic [5:0] OP_BNEQZ = 6'd13;
  localparam logic [5:0] OP_BEQZ  = 6'd14;
  localparam logic [5:0] OP_JUMP  = 6'd15;
  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_e;
  function automatic logic is_legal(input logic [5:0] op);
    return op <= OP_MUL || (op >= OP_LW && op <= OP_JUMP);
  endfunction
  function automatic logic is_imm_form(input logic [5:0] op);
    return op >= OP_LW && op <= OP_JUMP;
  endfunction
  function automatic logic is_branch(input logic [5:0] op);
    return op == OP_BNEQZ || op == OP_BEQZ;
  endfunction
endpackage

// File: rtl/alu_issue_ctrl_if.sv
// alu_issue_ctrl_if: decode-side and writeback-side valid/ready handshakes of the execute stage
interface alu_issue_ctrl_if #(parameter int DW = 32, parameter int IMMW = 16);
  logic            in_valid;
  logic            in_ready;
  logic [5:0]      in_opcode;
  logic [DW-1:0]   in_rs_val;
  logic [DW-1:0]   in_rt_val;
  logic [IMMW-1:0] in_imm;
  logic [DW-1:0]   in_npc;
  logic            out_valid;
  logic            out_ready;
  logic [DW-1:0]   out_result;
  logic [DW-1:0]   out_store_data;
  logic            out_cond;
  logic            out_illegal;
  modport master (
    output in_valid, in_opcode, in_rs_val, in_rt_val, in_imm, in_npc, out_ready,
    input  in_ready, out_valid, out_result, out_store_data, out_cond, out_illegal
  );
  modport slave (
    input  in_valid, in_opcode, in_rs_val, in_rt_val, in_imm, in_npc, out_ready,
    output in_ready, out_valid, out_result, out_store_data, out_cond, out_illegal
  );
endinterface

// File: rtl/alu_operand_mux.sv
// alu_operand_mux: forms ALU opcode and operands from a captured instruction; undefined codes become add 0+0
module alu_operand_mux import alu_pkg::*; #(
  parameter int DW   = 32,
  parameter int IMMW = 16
) (
  input  logic [5:0]      opcode_i,
  input  logic [DW-1:0]   rs_i,
  input  logic [DW-1:0]   rt_i,
  input  logic [IMMW-1:0] imm_i,
  input  logic [DW-1:0]   npc_i,
  output logic [5:0]      alu_opcode_o,
  output logic [DW-1:0]   alu_a_o,
  output logic [DW-1:0]   alu_b_o,
  output logic            illegal_o
);
  logic [DW-1:0] imm_x;
  logic          legal;
  assign imm_x        = {{(DW-IMMW){imm_i[IMMW-1]}}, imm_i};
  assign legal        = is_legal(opcode_i);
  assign illegal_o    = !legal;
  assign alu_opcode_o = legal ? opcode_i : OP_ADD;
  assign alu_a_o      = (!legal || opcode_i == OP_JUMP) ? '0 : is_branch(opcode_i) ? npc_i : rs_i;
  assign alu_b_o      = !legal ? '0 : is_imm_form(opcode_i) ? imm_x : rt_i;
endmodule

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: execute-stage initiator driving the combinational ALU between decode and writeback handshakes
// Optional EXEC_MUL_STALL_EN: MUL holds EXEC for 3 cycles with stable ALU operands
module alu_issue_ctrl import alu_pkg::*; #(
  parameter int DW   = 32,
  parameter int IMMW = 16
) (
  input  logic           clk,
  input  logic           rst,
  alu_issue_ctrl_if.slave ifc,
  output logic [5:0]     alu_opcode,
  output logic [DW-1:0]  alu_a,
  output logic [DW-1:0]  alu_b,
  input  logic [DW-1:0]  alu_out,
  output logic           busy
);
  state_e          state_q, state_d;
  logic [5:0]      op_q;
  logic [DW-1:0]   rs_q, rt_q, npc_q, res_q, sd_q;
  logic [IMMW-1:0] imm_q;
  logic            cond_q, ill_q, illegal, accept, exec_done;
  alu_operand_mux #(.DW(DW), .IMMW(IMMW)) u_mux (
    .opcode_i(op_q), .rs_i(rs_q), .rt_i(rt_q), .imm_i(imm_q), .npc_i(npc_q),
    .alu_opcode_o(alu_opcode), .alu_a_o(alu_a), .alu_b_o(alu_b), .illegal_o(illegal)
  );
`ifdef EXEC_MUL_STALL_EN
  logic [1:0] stall_q;
  assign exec_done = op_q != OP_MUL || stall_q == 2'd2;
  always_ff @(posedge clk)
    stall_q <= (rst || state_q != EXEC || exec_done) ? 2'd0 : stall_q + 2'd1;
`else
  assign exec_done = 1'b1;
`endif
  assign ifc.in_ready       = state_q == IDLE || (state_q == DONE && ifc.out_ready);
  assign accept             = ifc.in_valid && ifc.in_ready;
  assign ifc.out_valid      = state_q == DONE;
  assign ifc.out_result     = res_q;
  assign ifc.out_store_data = sd_q;
  assign ifc.out_cond       = cond_q;
  assign ifc.out_illegal    = ill_q;
  assign busy               = state_q != IDLE;
  always_comb
    state_d = state_q == IDLE ? (accept ? EXEC : IDLE) :
              state_q == EXEC ? (exec_done ? DONE : EXEC) :
              !ifc.out_ready  ? DONE : accept ? EXEC : IDLE;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      op_q    <= '0;
      rs_q    <= '0;
      rt_q    <= '0;
      imm_q   <= '0;
      npc_q   <= '0;
      res_q   <= '0;
      sd_q    <= '0;
      cond_q  <= 1'b0;
      ill_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        op_q  <= ifc.in_opcode;
        rs_q  <= ifc.in_rs_val;
        rt_q  <= ifc.in_rt_val;
        imm_q <= ifc.in_imm;
        npc_q <= ifc.in_npc;
      end
      if (state_q == EXEC && exec_done) begin
        res_q  <= illegal ? '0 : alu_out;
        sd_q   <= rt_q;
        ill_q  <= illegal;
        cond_q <= op_q == OP_BEQZ ? rs_q == '0 : (op_q == OP_BNEQZ && rs_q != '0);
      end
    end
  end
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb_alu_issue_ctrl: randomized scoreboard bench with a spec-level reference model and an ALU model
module tb_alu_issue_ctrl;
  import alu_pkg::*;
  typedef struct {
    logic [31:0] res, sd, a, b;
    logic [5:0]  aop;
    logic        cond, ill;
    int          acc, lat;
  } exp_t;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [5:0]  alu_opcode;
  logic [31:0] alu_a, alu_b, alu_out;
  logic        busy;
  int          cyc = 0, total = 0, bad = 0, rdy_mode = 0;
  bit          first = 1'b1;
  exp_t        exp_q[$];
  exp_t        m;
  logic [5:0]  r_op;
  logic [31:0] r_rs;
  alu_issue_ctrl_if #(.DW(32), .IMMW(16)) ifc();
  alu_issue_ctrl #(.DW(32), .IMMW(16)) dut (
    .clk(clk), .rst(rst), .ifc(ifc), .alu_opcode(alu_opcode),
    .alu_a(alu_a), .alu_b(alu_b), .alu_out(alu_out), .busy(busy)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  // combinational ALU as seen by the block
  always_comb
    case (alu_opcode)
      6'd1, 6'd11: alu_out = alu_a - alu_b;
      6'd2:        alu_out = alu_a & alu_b;
      6'd3:        alu_out = alu_a | alu_b;
      6'd4, 6'd12: alu_out = {31'd0, alu_a < alu_b};
      6'd5:        alu_out = alu_a * alu_b;
      default:     alu_out = alu_a + alu_b;
    endcase
  function automatic exp_t model(input logic [5:0] op, input logic [31:0] rs, rt,
                                 input logic [15:0] imm, input logic [31:0] npc);
    exp_t e;
    logic [31:0] sx;
    bit legal;
    sx = {{16{imm[15]}}, imm};
    legal = op <= 6'd5 || (op >= 6'd8 && op <= 6'd15);
    case (op)
      6'd0:              e.res = rs + rt;
      6'd1:              e.res = rs - rt;
      6'd2:              e.res = rs & rt;
      6'd3:              e.res = rs | rt;
      6'd4:              e.res = (rs < rt) ? 32'd1 : 32'd0;
      6'd5:              e.res = rs * rt;
      6'd8, 6'd9, 6'd10: e.res = rs + sx;
      6'd11:             e.res = rs - sx;
      6'd12:             e.res = (rs < sx) ? 32'd1 : 32'd0;
      6'd13, 6'd14:      e.res = npc + sx;
      6'd15:             e.res = sx;
      default:           e.res = 32'd0;
    endcase
    e.sd   = rt;
    e.cond = op == 6'd14 ? rs == 0 : op == 6'd13 ? rs != 0 : 1'b0;
    e.ill  = !legal;
    e.aop  = legal ? op : 6'd0;
    e.a    = (!legal || op == 6'd15) ? 32'd0 : (op == 6'd13 || op == 6'd14) ? npc : rs;
    e.b    = !legal ? 32'd0 : op <= 6'd5 ? rt : sx;
    e.lat  = 1;
`ifdef EXEC_MUL_STALL_EN
    if (op == 6'd5) e.lat = 3;
`endif
    e.acc  = 0;
    return e;
  endfunction
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, want, cyc);
    end
  endtask
  task automatic chk_reset(input string tag);
    chk({tag, "_in_ready"}, {31'd0, ifc.in_ready}, 32'd1);
    chk({tag, "_out_valid"}, {31'd0, ifc.out_valid}, 32'd0);
    chk({tag, "_out_result"}, ifc.out_result, 32'd0);
    chk({tag, "_out_store_data"}, ifc.out_store_data, 32'd0);
    chk({tag, "_out_cond"}, {31'd0, ifc.out_cond}, 32'd0);
    chk({tag, "_out_illegal"}, {31'd0, ifc.out_illegal}, 32'd0);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_alu_opcode"}, {26'd0, alu_opcode}, 32'd0);
    chk({tag, "_alu_a"}, alu_a, 32'd0);
    chk({tag, "_alu_b"}, alu_b, 32'd0);
  endtask
  task automatic issue(input logic [5:0] op, input logic [31:0] rs, rt,
                       input logic [15:0] imm, input logic [31:0] npc);
    int n = 0;
    exp_t e;
    ifc.in_valid  = 1'b1;
    ifc.in_opcode = op;
    ifc.in_rs_val = rs;
    ifc.in_rt_val = rt;
    ifc.in_imm    = imm;
    ifc.in_npc    = npc;
    @(negedge clk);
    while (!ifc.in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      total++;
      bad++;
      $display("FAIL accept_timeout: in_ready got 0 want 1");
      ifc.in_valid = 1'b0;
      return;
    end
    e = model(op, rs, rt, imm, npc);
    @(posedge clk);
    #1;
    e.acc = cyc;
    exp_q.push_back(e);
    ifc.in_valid = 1'b0;
  endtask
  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 2000) begin
      @(posedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain_timeout: outstanding got %0d want 0", exp_q.size());
      exp_q.delete();
    end
    @(posedge clk);
    #1;
  endtask
  initial begin
    ifc.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      ifc.out_ready = rdy_mode == 1 ? 1'($urandom_range(0, 1)) : rdy_mode == 0;
    end
  end
  // monitor: compares every cycle a result is held, pops on transfer
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        first = 1'b1;
        continue;
      end
      if (!ifc.out_valid) continue;
      if (exp_q.size() == 0) begin
        chk("unexpected_out_valid", {31'd0, ifc.out_valid}, 32'd0);
        continue;
      end
      e = exp_q[0];
      if (first) begin
        chk("latency", 32'(cyc - e.acc), 32'(e.lat));
        first = 1'b0;
      end
      chk("out_result", ifc.out_result, e.res);
      chk("out_store_data", ifc.out_store_data, e.sd);
      chk("out_cond", {31'd0, ifc.out_cond}, {31'd0, e.cond});
      chk("out_illegal", {31'd0, ifc.out_illegal}, {31'd0, e.ill});
      chk("alu_opcode", {26'd0, alu_opcode}, {26'd0, e.aop});
      chk("alu_a", alu_a, e.a);
      chk("alu_b", alu_b, e.b);
      chk("in_ready_done", {31'd0, ifc.in_ready}, {31'd0, ifc.out_ready});
      if (ifc.out_ready) begin
        void'(exp_q.pop_front());
        first = 1'b1;
      end
    end
  end
  initial begin
    #500000;
    $display("FAIL watchdog: cycle got %0d want completion", cyc);
    $fatal(1, "watchdog");
  end
  initial begin
    ifc.in_valid  = 1'b0;
    ifc.in_opcode = '0;
    ifc.in_rs_val = '0;
    ifc.in_rt_val = '0;
    ifc.in_imm    = '0;
    ifc.in_npc    = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_reset("reset");
    @(posedge clk);
    #1;
    rst = 1'b0;
    issue(OP_ADDI, 32'd5, 32'd0, 16'hFFFF, 32'd0);
    drain();
    issue(OP_BEQZ, 32'd0, 32'd0, 16'd3, 32'h10);
    issue(OP_BEQZ, 32'd7, 32'd0, 16'd3, 32'h10);
    issue(OP_BNEQZ, 32'd7, 32'd0, 16'd3, 32'h10);
    drain();
    rdy_mode = 2;
    issue(OP_SW, 32'h100, 32'hDEAD, 16'd4, 32'd0);
    repeat (6) @(posedge clk);
    #1;
    rdy_mode = 0;
    drain();
    issue(OP_MUL, 32'h10000, 32'h10000, 16'd0, 32'd0);
    issue(OP_LW, 32'h200, 32'd0, 16'hFFFC, 32'd0);
    issue(OP_SUBI, 32'd1, 32'd0, 16'd2, 32'd0);
    issue(OP_SLT, 32'd1, 32'hFFFFFFFF, 16'd0, 32'd0);
    issue(OP_SLTI, 32'd3, 32'd0, 16'hFFFF, 32'd0);
    issue(OP_OR, 32'hF0, 32'h0F, 16'd0, 32'd0);
    issue(OP_JUMP, 32'h55, 32'd0, 16'h8000, 32'h99);
    drain();
    issue(6'd6, 32'h1234, 32'h5678, 16'h9, 32'h40);
    drain();
    issue(OP_ADD, 32'd3, 32'd5, 16'd0, 32'd0);
    issue(OP_SUB, 32'd3, 32'd5, 16'd0, 32'd0);
    drain();
    issue(OP_AND, 32'hF0F0, 32'hFF00, 16'd0, 32'd0);
    rst = 1'b1;
    exp_q.delete();
    @(posedge clk);
    @(negedge clk);
    chk_reset("mid_exec_reset");
    @(posedge clk);
    #1;
    rst = 1'b0;
    rdy_mode = 1;
    for (int i = 0; i < 300; i++) begin
      r_op = 6'($urandom_range(0, 15));
      r_rs = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
      issue(r_op, r_rs, $urandom, 16'($urandom), $urandom);
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
    end
    drain();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/alu_issue_ctrl.md
# alu_issue_ctrl

Execute-stage initiator for the 32-bit combinational ALU. Accepts one decoded instruction per valid/ready handshake, forms the ALU opcode and operands (register, sign-extended immediate, or next-PC), samples the ALU result, resolves the branch condition, and presents a registered result to writeback/memory over a second valid/ready handshake. It sits between the decode stage and the memory/writeback stage, and it is the only driver of the ALU's opcode, A and B inputs.

## Interface
- DW, 32: datapath width
- IMMW, 16: immediate width, sign-extended to DW
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  decoded instruction offered
- in_ready  out  1  block can accept this cycle
- in_opcode  in  6  instruction opcode
- in_rs_val  in  DW  rs register value
- in_rt_val  in  DW  rt register value
- in_imm  in  IMMW  raw immediate
- in_npc  in  DW  next PC (PC+1)
- alu_opcode  out  6  to ALU
- alu_a  out  DW  to ALU
- alu_b  out  DW  to ALU
- alu_out  in  DW  from ALU (combinational)
- out_valid  out  1  result held
- out_ready  in  1  consumer accepts
- out_result  out  DW  ALU result or target address
- out_store_data  out  DW  rt value, for SW
- out_cond  out  1  branch taken (BEQZ/BNEQZ only, else 0)
- out_illegal  out  1  undefined opcode
- busy  out  1  state != IDLE

## Operation
- Opcode set: add 0, sub 1, AND 2, OR 3, SLT 4, MUL 5, LW 8, SW 9, addi 10, subi 11, SLTi 12, BNEQZ 13, BEQZ 14, jump 15. All other values are illegal.
- Operand selection:
  - R-type (0–5): A = rs, B = rt.
  - LW/SW/addi/subi/SLTi: A = rs, B = sext(imm).
  - BEQZ/BNEQZ: A = npc, B = sext(imm).
  - jump: A = 0, B = sext(imm).
- Branch condition: BEQZ → out_cond = (rs == 0); BNEQZ → out_cond = (rs != 0). The condition is computed from the captured rs.
- Illegal opcode:
  - alu_opcode is driven to add (0) with A = B = 0, so the ALU never sees an undefined code.
  - out_result = 0, out_illegal = 1, out_cond = 0.
- FSM states:
  - IDLE: in_ready = 1. On accept, capture opcode, rs, rt, imm and npc into operand registers and go to EXEC.
  - EXEC: drive the ALU from the operand registers. When done, register alu_out into out_result and go to DONE.
  - DONE: out_valid = 1, all out_* signals held stable.
    - out_ready = 1 and in_valid = 1: accept the new instruction, go to EXEC.
    - out_ready = 1 and in_valid = 0: go to IDLE.
    - out_ready = 0: stay in DONE.
- in_ready = (state == IDLE) or (state == DONE and out_ready).
- Outside EXEC, the alu_* outputs still reflect the operand registers. No downstream logic samples them there.
- Arithmetic: all results are truncated to DW bits. MUL keeps the low DW bits. SLT/SLTi compare unsigned, matching the ALU.

## Timing
- Reset values: state = IDLE, in_ready = 1, out_valid = 0, out_result = 0, out_store_data = 0, out_cond = 0, out_illegal = 0, busy = 0. Operand registers are 0 and alu_opcode = 0.
- Latency: an accept at edge T makes out_valid = 1 from cycle T+2, for all non-MUL ops and for MUL when EXEC_MUL_STALL_EN is undefined.
- Throughput: one instruction per 2 cycles, with out_ready held high.
- Backpressure: out_* signals are stable while out_valid && !out_ready. No result is dropped or overwritten.
- rst asserted in any state, including mid-EXEC and mid-stall: on the next edge all registers return to their reset values. Any in-flight instruction is discarded with no output.
- If in_valid and rst are high in the same cycle, the input is not accepted.

## Configuration
- EXEC_MUL_STALL_EN defined:
  - MUL stays in EXEC for 3 cycles, counted by a 2-bit stall counter.
  - ALU operands are held constant for all 3 cycles, and alu_out is sampled on the last one.
  - MUL latency is accept + 4.
- Undefined: MUL behaves like every other op (1 EXEC cycle) and the stall counter is not built.

## Structure
- Shared package, alu_pkg:
  - opcode localparams, identical values to the ALU
  - FSM state enum {IDLE, EXEC, DONE}
  - function is_imm_form(opcode)
  - function is_branch(opcode)
  - function is_legal(opcode)
- One natural sub-module, alu_operand_mux: a combinational block that takes opcode, rs, rt, imm and npc and produces alu_opcode, alu_a, alu_b and illegal.
- The FSM, stall counter and output registers live in the top module.

## Test plan
- addi, rs = 5, imm = 0xFFFF, out_ready = 1: ALU sees A = 5, B = 0xFFFFFFFF; out_result = 4 at T+2, out_valid pulses for 1 cycle.
- BEQZ, rs = 0, npc = 0x10, imm = 3: out_result = 0x13, out_cond = 1. Repeat with rs = 7: out_cond = 0. BNEQZ with rs = 7: out_cond = 1.
- SW, rs = 0x100, rt = 0xDEAD, imm = 4, out_ready = 0 for 5 cycles: out_result = 0x104 and out_store_data = 0xDEAD stay stable; in_ready = 0 until out_ready rises.
- MUL, rs = 0x10000, rt = 0x10000: out_result = 0. With EXEC_MUL_STALL_EN, out_valid rises at T+4; without it, at T+2.
- Opcode 6: out_illegal = 1, out_result = 0, ALU driven with opcode 0 and A = B = 0.
- Back-to-back add then sub (3 − 5) with in_valid held high and out_ready = 1: results 8 then 0xFFFFFFFE, 2 cycles apart. Assert rst mid-EXEC of a third op: no out_valid, all outputs at their reset values on the next edge.
